// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronised rising edges of sig_in over a
// window of GATE_CYCLES clk cycles and publishes the saturating count.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             continuous,
  output logic [CNT_W-1:0] freq_out,
  output logic             freq_valid,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned        GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]   CNT_PRE   = CNT_MAX - CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GATE,
    S_LATCH
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_s1;
  logic              r_s2;
  logic              r_s3;
  logic              w_edge;
  logic [GATE_W-1:0] r_gate_cnt;
  logic [CNT_W-1:0]  r_edge_cnt;
  logic              r_sat;
  logic              w_gate_entry;
  logic              w_counting;
  logic              w_publish;
  logic              w_busy_next;

  // Two-flop synchroniser plus a delay flop for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge = r_s2 & ~r_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_GATE;
      S_GATE:  if (r_gate_cnt == GATE_LAST) w_next = S_LATCH;
      S_LATCH: w_next = continuous ? S_GATE : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_gate_entry = (r_state != S_GATE) && (w_next == S_GATE);
    w_counting   = (r_state == S_GATE);
    w_publish    = (r_state == S_LATCH);
    w_busy_next  = (w_next != S_IDLE);
  end

  // Counters clear on every GATE entry; the edge counter saturates and the
  // sticky flag marks reaching or exceeding full scale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_sat      <= 1'b0;
    end else if (w_gate_entry) begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_sat      <= 1'b0;
    end else if (w_counting) begin
      r_gate_cnt <= r_gate_cnt + GATE_W'(1);
      if (w_edge) begin
        if (r_edge_cnt == CNT_MAX) begin
          r_sat <= 1'b1;
        end else begin
          r_edge_cnt <= r_edge_cnt + CNT_W'(1);
          if (r_edge_cnt == CNT_PRE) r_sat <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_out   <= '0;
      freq_valid <= 1'b0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      freq_valid <= w_publish;
      busy       <= w_busy_next;
      if (w_publish) begin
        freq_out <= r_edge_cnt;
        overflow <= r_sat;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: a per-cycle sig_in plan is written ahead of
// time, expected window counts are derived from it and checked on freq_valid.
module tb_freq_meter;

  localparam int G      = 100;
  localparam int CW     = 4;
  localparam int MAXV   = 15;
  localparam int PLAN_N = 8192;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sig_in = 1'b0;
  logic          start;
  logic          continuous;
  logic [CW-1:0] freq_out;
  logic          freq_valid;
  logic          overflow;
  logic          busy;

  freq_meter #(
    .GATE_CYCLES(G),
    .CNT_W      (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .start     (start),
    .continuous(continuous),
    .freq_out  (freq_out),
    .freq_valid(freq_valid),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int f;
    int ovf;
  } exp_t;

  exp_t sb[$];
  bit   plan[PLAN_N];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // plan[e] is driven after the negedge following edge e, so edge e+1 samples it
  initial begin
    forever begin
      @(negedge clk);
      #1;
      sig_in = (cyc < PLAN_N) ? plan[cyc] : 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic fill_sq(input int lo, input int hi, input int period, input int hlen, input int first);
    for (int r = lo; r < hi && r < PLAN_N; r++)
      plan[r] = (r >= first) && (((r - first) % period) < hlen);
  endtask

  task automatic fill_const(input int lo, input int hi, input bit v);
    for (int r = lo; r < hi && r < PLAN_N; r++) plan[r] = v;
  endtask

  task automatic fill_rand(input int lo, input int hi);
    for (int r = lo; r < hi && r < PLAN_N; r++) plan[r] = bit'($urandom_range(0, 1));
  endtask

  // A window started by the edge n counts sig_in rises seen at plan indices
  // n-2 .. n+G-3 (three cycles of synchroniser and edge-detect latency).
  function automatic int raw_count(input int n);
    int c = 0;
    for (int r = n - 2; r <= n + G - 3; r++)
      if (plan[r] && !plan[r-1]) c++;
    return c;
  endfunction

  task automatic push_window(input int n);
    exp_t e;
    int   raw;
    raw   = raw_count(n);
    e.due = n + G + 1;
    e.f   = (raw > MAXV) ? MAXV : raw;
    e.ovf = (raw >= MAXV) ? 1 : 0;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0 && cyc > sb[0].due) begin
      checks++;
      errors++;
      $display("FAIL missing_result: got no freq_valid, expected one at cycle %0d", sb[0].due);
      void'(sb.pop_front());
    end
    if (freq_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got freq_valid at cycle %0d, expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk("valid_cycle", cyc, e.due);
        chk("freq_out", int'(freq_out), e.f);
        chk("overflow", int'(overflow), e.ovf);
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 50) begin
      tick();
      n++;
    end
    chk("scoreboard_drained", sb.size(), 0);
    sb.delete();
  endtask

  // Call at a negedge after the plan has been written from cyc onward.
  task automatic run_windows(input int nwin, input bit extra_start);
    int n0;
    int last;
    n0 = cyc + 1;
    for (int k = 0; k < nwin; k++) push_window(n0 + k * (G + 1));
    start      = 1'b1;
    continuous = (nwin > 1);
    tick();
    start = 1'b0;
    last  = n0 + nwin * (G + 1) - 1;
    while (cyc <= last) begin
      chk("busy_high", int'(busy), 1);
      start = extra_start && (cyc == n0 + 30 || cyc == last);
      if (nwin > 1 && cyc == n0 + (nwin - 1) * (G + 1) + 50) continuous = 1'b0;
      tick();
    end
    start = 1'b0;
    repeat (5) begin
      chk("busy_low_after", int'(busy), 0);
      tick();
    end
    drain();
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int n;
    int nw;
    int p;
    int h;
    for (int i = 0; i < 24; i++) plan[i] = bit'(i % 2);
    rst_n      = 1'b0;
    start      = 1'b0;
    continuous = 1'b0;

    repeat (8) begin
      tick();
      chk("rst_freq_out", int'(freq_out), 0);
      chk("rst_valid", int'(freq_valid), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_busy", int'(busy), 0);
    end
    rst_n = 1'b1;
    repeat (25) begin
      tick();
      chk("idle_busy", int'(busy), 0);
    end

    // Basic: period 10, first rise shortly after start
    n = cyc + 1;
    fill_sq(cyc, n + G + 10, 10, 5, n + 4);
    run_windows(1, 1'b0);

    // Continuous: period 20 over four windows, continuous dropped in the last
    n = cyc + 1;
    fill_sq(cyc, n + 4 * (G + 1) + 10, 20, 10, n + 7);
    run_windows(4, 1'b0);

    // Saturation: period 4 then a silent window
    n = cyc + 1;
    fill_sq(cyc, n + G - 2, 4, 2, n);
    fill_const(n + G - 2, n + 2 * (G + 1) + 10, 1'b0);
    run_windows(2, 1'b0);

    // Start pulses during GATE and LATCH must be ignored
    n = cyc + 1;
    fill_sq(cyc, n + G + 10, 7, 3, n + 2);
    run_windows(1, 1'b1);

    // Reset in the middle of a window
    n = cyc + 1;
    fill_sq(cyc, n + G + 10, 9, 4, n + 1);
    push_window(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < n + 50) tick();
    rst_n = 1'b0;
    fill_const(cyc, cyc + 20, 1'b0);
    sb.delete();
    #1;
    chk("midrst_freq_out", int'(freq_out), 0);
    chk("midrst_valid", int'(freq_valid), 0);
    chk("midrst_overflow", int'(overflow), 0);
    chk("midrst_busy", int'(busy), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) begin
      tick();
      chk("post_rst_busy", int'(busy), 0);
    end
    n = cyc + 1;
    fill_sq(cyc, n + G + 10, 6, 3, n + 3);
    run_windows(1, 1'b0);

    // Randomised windows
    for (int k = 0; k < 6; k++) begin
      nw = int'($urandom_range(1, 2));
      n  = cyc + 1;
      if (k == 5) begin
        fill_rand(cyc, n + nw * (G + 1) + 10);
      end else begin
        p = int'($urandom_range(3, 25));
        h = int'($urandom_range(1, p - 1));
        fill_sq(cyc, n + nw * (G + 1) + 10, p, h, cyc + int'($urandom_range(0, p)));
      end
      run_windows(nw, bit'(k % 2));
      repeat ($urandom_range(0, 5)) tick();
    end

    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
# freq_meter

Gated frequency counter: it counts rising edges of an asynchronous input `sig_in` over a fixed window of `GATE_CYCLES` `clk` cycles, then publishes the count. A 1 s window at 50 MHz yields the input frequency directly in Hz. It is the measuring end of the clock-divider chain and checks divided clocks such as the 1 Hz tick against the system clock. Capture can be single-shot or continuous.

## Interface
- `GATE_CYCLES`, default 50_000_000: window length in `clk` cycles; must be ≥ 2.
- `CNT_W`, default 26: width of the edge counter and of the result.
- `clk`  in  1: system clock, rising edge active.
- `rst_n`  in  1: asynchronous, active-low reset.
- `sig_in`  in  1: measured signal, asynchronous to `clk`.
- `start`  in  1: starts a measurement; sampled only in IDLE.
- `continuous`  in  1: when 1, a new window starts immediately after each result; sampled in LATCH.
- `freq_out`  out  CNT_W: edge count of the last completed window; held until the next LATCH.
- `freq_valid`  out  1: one-cycle pulse, asserted the cycle `freq_out` updates.
- `overflow`  out  1: the last window saturated; updated together with `freq_out`.
- `busy`  out  1: high in GATE and LATCH.

## Operation
- **Input conditioning:** `sig_in` passes through a 2-flop synchronizer (s1, s2) and a delay flop s3. The edge pulse is `s2 & ~s3`. All three flops reset to 0.
- **FSM states:**
  - IDLE: waits for `start`.
  - GATE: counts edges for the window.
  - LATCH: publishes the result.
- **IDLE → GATE** when `start` = 1. On entry, `gate_cnt` and `edge_cnt` clear to 0.
- **GATE:**
  - `gate_cnt` increments every cycle.
  - `edge_cnt` increments on each edge pulse.
  - When `gate_cnt == GATE_CYCLES-1`, go to LATCH. An edge pulse in that last cycle is counted.
  - The window is exactly `GATE_CYCLES` cycles.
- **LATCH (1 cycle):**
  - `freq_out` ← `edge_cnt`; `overflow` ← saturation flag; `freq_valid` = 1.
  - Then go to GATE with both counters cleared if `continuous` = 1, else to IDLE.
  - Edge pulses during LATCH are not counted, so each window has 1 dead cycle.
- **Saturation:**
  - `edge_cnt` saturates at 2^CNT_W−1 and never wraps.
  - A sticky internal flag sets on any edge pulse arriving while the counter is saturated or at the increment that reaches the saturation value.
  - The flag clears on GATE entry.
- **Input frequency limit:** inputs above CLK_HZ/2 alias and are undercounted; this is not detected. High and low phases must each be ≥ 1 `clk` period to be counted reliably.
- **Simultaneous events:**
  - `start` while busy is ignored.
  - `continuous` dropped mid-window: the current window completes and the result is published, then IDLE.
  - `start` and `continuous` both high in IDLE: continuous run begins.
- **Reset mid-operation:** the FSM returns to IDLE at once and every register clears; no `freq_valid` pulse is produced.

## Timing
- Reset values: `freq_out` = 0, `freq_valid` = 0, `overflow` = 0, `busy` = 0, state IDLE, all counters 0.
- Start latency:
  - `start` high at edge N → state GATE from edge N.
  - `busy` high in cycle N+1.
  - The first counted cycle is N+1.
- Result latency:
  - LATCH occurs `GATE_CYCLES` cycles after GATE entry.
  - `freq_out`, `overflow` and `freq_valid` update on the edge that leaves LATCH, i.e. `GATE_CYCLES`+1 cycles after `start`.
- Input latency: a `sig_in` rise becomes an edge pulse 2–3 `clk` edges later. An edge falling within 3 cycles of a window boundary may be counted in the adjacent window.
- Continuous-mode result period: `GATE_CYCLES`+1 cycles. `busy` stays high throughout.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert `rst_n` = 0 with `sig_in` toggling → all outputs 0; after release, no `freq_valid` until `start`.
- Basic count (GATE_CYCLES = 100):
  - Stimulus: `sig_in` period 10 clk, first rise 5 clk after `start`; single `start` pulse.
  - Required: exactly one `freq_valid`, 101 cycles after `start`; `freq_out` = 10; `overflow` = 0; `busy` low afterwards.
- Continuous (GATE_CYCLES = 100):
  - Stimulus: `sig_in` period 20 clk, `continuous` = 1.
  - Required: `freq_valid` every 101 cycles; `freq_out` ∈ {5}, 5 throughout with phase held fixed relative to window.
  - Then drop `continuous` mid-window → one more result, then IDLE.
- Saturation (CNT_W = 4, GATE_CYCLES = 100):
  - Stimulus: `sig_in` period 4 clk.
  - Required: `freq_out` = 15, `overflow` = 1. The next window with `sig_in` held low gives `freq_out` = 0, `overflow` = 0.
- Start while busy: pulse `start` during GATE and during LATCH → window timing unchanged; no extra result.
- Reset mid-window: drop `rst_n` at `gate_cnt` = 50 → outputs 0 and IDLE immediately. A fresh `start` afterwards gives a correct full-window count.
